// File: rtl/lsu.sv
// Load/store unit between the core and the data port of the unified memory.
// Sub-word stores are read-modify-write because the memory only writes whole words.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr_d,
  input  logic [31:0] rdata,
  output logic        wen,
  output logic [31:0] wdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RDATA = 2'd2, WR = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic        store_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;
  logic [15:0] sdata_reg;
  logic        illegal;

  function automatic logic [31:0] extract_lane(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Only SB (funct3 0) and SH (funct3 1) ever reach the merge.
  function automatic logic [31:0] merge_lane(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w, input logic [15:0] sd);
    logic [31:0] r;
    r = w;
    if (f3[0] == 1'b0) begin
      case (lane)
        2'd0:    r[7:0]   = sd[7:0];
        2'd1:    r[15:8]  = sd[7:0];
        2'd2:    r[23:16] = sd[7:0];
        default: r[31:24] = sd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = sd;
    end else begin
      r[15:0] = sd;
    end
    return r;
  endfunction

  // Store widths above word and the unused load codes 3/6/7 are rejected outright.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = req_addr[0];
      3'd2:    illegal = (req_addr[1:0] != 2'b00);
      3'd4:    illegal = req_wen;
      3'd5:    illegal = req_wen | req_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && !illegal)
          state_next = (req_wen && req_funct3 == 3'd2) ? WR : RD;
      end
      RD:      state_next = RDATA;
      RDATA:   state_next = store_reg ? WR : IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_reg  <= 1'b0;
      funct3_reg <= 3'd0;
      lane_reg   <= 2'd0;
      sdata_reg  <= 16'd0;
      addr_d     <= 32'd0;
      wen        <= 1'b0;
      wdata      <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            store_reg  <= req_wen;
            funct3_reg <= req_funct3;
            lane_reg   <= req_addr[1:0];
            sdata_reg  <= req_wdata[15:0];
            if (illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              addr_d <= {req_addr[31:2], 2'b00};
              if (req_wen && req_funct3 == 3'd2) begin
                wen   <= 1'b1;
                wdata <= req_wdata;
              end
            end
          end
        end
        RDATA: begin
          if (store_reg) begin
            wen   <= 1'b1;
            wdata <= merge_lane(funct3_reg, lane_reg, rdata, sdata_reg);
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extract_lane(funct3_reg, lane_reg, rdata);
          end
        end
        WR: begin
          wen        <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have no parameters; all words are WORD_LEN (32) bits, taken from consts.vh.
REQ-002 SHALL have one clock, with reset asynchronous and active-high, on these ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have these request-side ports:
- req_valid  in  1  request present.
- req_ready  out  1  request accepted at the edge where req_valid&req_ready.
- req_wen  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
REQ-004 SHALL have these response-side ports:
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  misaligned or illegal access.
REQ-005 SHALL have these dmem-side ports, wired directly to the data port of the unified memory:
- addr_d  out  32  word address; bits [1:0] are driven 0.
- rdata  in  32  registered read data, valid one cycle after addr_d is presented.
- wen  out  1  word write enable.
- wdata  out  32  full word to write.

Function
REQ-006 SHALL implement FSM states IDLE, RD, RDATA, WR; req_ready=1 only in IDLE (combinational).
REQ-007 On acceptance SHALL latch addr, funct3, wen and wdata; req_* inputs are ignored outside IDLE.
REQ-008 Illegal access SHALL be:
- LH/LHU/SH with addr[0]=1;
- LW/SW with addr[1:0]!=0;
- load funct3 in {3,6,7};
- store funct3 >2.
Illegal access SHALL issue no memory access, stay in IDLE, and register resp_valid=1, resp_err=1, resp_rdata=0 at the acceptance edge N.
REQ-009 Load SHALL follow: edge N IDLE->RD (addr_d=addr&~3); N+1 RD->RDATA; N+2 RDATA->IDLE, registering resp_valid=1, resp_err=0, resp_rdata=extract(rdata).
REQ-010 Extraction SHALL select byte lane addr[1:0] (little-endian) or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-011 SW SHALL follow: edge N IDLE->WR (wen=1, wdata=req_wdata); N+1 WR->IDLE, registering resp_valid=1, resp_rdata=0.
REQ-012 SB/SH SHALL perform read-modify-write: N IDLE->RD; N+1 ->RDATA; N+2 ->WR with wdata=rdata with only the addressed lane replaced by the low 8/16 bits of the store data; N+3 WR->IDLE, registering resp_valid=1.
REQ-013 wen SHALL be 1 only in WR, for exactly one cycle per store; addr_d SHALL be held stable from RD/WR entry until return to IDLE.
REQ-014 resp_valid SHALL be high for exactly one cycle per accepted request; resp_rdata/resp_err are held until the next response.
REQ-015 A new request SHALL be acceptable in the same cycle resp_valid is high (back-to-back, no bubble beyond the FSM).
REQ-016 A store followed by a load to the same word SHALL return the stored data, since the write completes before the load's RD state.

Reset
REQ-017 rst=1 SHALL asynchronously force:
- state=IDLE;
- wen=0, addr_d=0, wdata=0;
- resp_valid=0, resp_rdata=0, resp_err=0;
- req_ready=1 after release.
REQ-018 Reset asserted mid-operation SHALL abort it with no write issued and no response pulse; a read-modify-write aborted in RD/RDATA leaves memory unchanged.

Verification
REQ-019 Memory word 0x10 = 0x8899AABB; LB addr 0x12 -> resp_rdata=0xFFFFFF99 at N+2; LBU -> 0x00000099; LHU addr 0x12 -> 0x00008899.
REQ-020 SW 0x11223344 to 0x20 -> wen one cycle at state WR, resp_valid at N+1; then LW 0x20 -> 0x11223344.
REQ-021 Word 0x20 = 0x11223344; SB 0xA5 to 0x21 -> word becomes 0x1122A544, resp_valid at N+3; SH 0xBEEF to 0x22 -> 0xBEEFA544.
REQ-022 LW addr 0x22, SH addr 0x23, load funct3=3 -> resp_err=1 at N, wen never asserted, next request accepted immediately.
REQ-023 Assert rst during WR of SB -> wen drops immediately, no resp_valid, target word unchanged, req_ready=1 after release.
REQ-024 Ten back-to-back random loads/stores with req_valid held high -> responses in order, one per request, matching a reference memory model.
